alu_muldiv_ctrl: RTL and testbench

- Parametrised successor to the single-cycle ALU control decoder.
- Decodes AluOp/FnField to AluCtrl over a wider opcode set.
- Adds an iterative multiply/divide sequencer with HI/LO registers and a stall handshake to the datapath.
- Sits between the main control unit, the register-file read ports and the ALU. Drives AluCtrl to the ALU and HI/LO to the writeback mux.

---
 rtl/alu_muldiv_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_alu_muldiv_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_ctrl.sv
// ============================================================================
// Module   : alu_muldiv_ctrl
// Purpose  : ALU control decoder plus iterative multiply/divide sequencer with HI/LO
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_muldiv_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       AluOp,
  input  logic [5:0]       FnField,
  input  logic             issue,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [3:0]       AluCtrl,
  output logic             illegal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             stall
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_LAST = WIDTH - 1;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic               neg_a;
  logic               neg_b;
  logic               op_div;

  logic               rtype;
  logic               md_group;
  logic               is_mul;
  logic               is_div;
  logic               is_mthi;
  logic               is_mtlo;
  logic               md_signed;
  logic               go;
  logic               start_mul;
  logic               start_div;
  logic               div0;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_qbit;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] prod_res;
  logic [WIDTH-1:0]   quot_res;
  logic [WIDTH-1:0]   rem_res;

  // ---------------------------------------------------------------- decode
  assign rtype     = (AluOp == 2'b10);
  assign md_group  = (FnField[5:2] == 4'b0100) || (FnField[5:2] == 4'b0110);
  assign is_mul    = rtype && (FnField[5:1] == 5'b01100);
  assign is_div    = rtype && (FnField[5:1] == 5'b01101);
  assign is_mthi   = rtype && (FnField == 6'b010001);
  assign is_mtlo   = rtype && (FnField == 6'b010011);
  assign md_signed = ~FnField[0];

  always_comb begin
    AluCtrl = 4'b1111;
    illegal = 1'b0;
    case (AluOp)
      2'b00: AluCtrl = 4'b0010;
      2'b01: AluCtrl = 4'b0110;
      2'b11: AluCtrl = 4'b0001;
      default: begin
        if (md_group) begin
          AluCtrl = 4'b0010;
        end else begin
          case (FnField)
            6'b100000: AluCtrl = 4'b0010;
            6'b100010: AluCtrl = 4'b0110;
            6'b100100: AluCtrl = 4'b0000;
            6'b100101: AluCtrl = 4'b0001;
            6'b100110: AluCtrl = 4'b0011;
            6'b100111: AluCtrl = 4'b1100;
            6'b101010: AluCtrl = 4'b0111;
            6'b101011: AluCtrl = 4'b1000;
            default: begin
              AluCtrl = 4'b1111;
              illegal = 1'b1;
            end
          endcase
        end
      end
    endcase
  end

  assign busy  = (state != IDLE);
  assign stall = busy && issue && rtype && md_group;

  // Mul/div requests are only honoured from IDLE; anything arriving while busy is stalled.
  assign go        = (state == IDLE) && issue;
  assign start_mul = go && is_mul;
  assign start_div = go && is_div && (src_b != '0);
  assign div0      = go && is_div && (src_b == '0);

  assign a_neg = md_signed && src_a[WIDTH-1];
  assign b_neg = md_signed && src_b[WIDTH-1];
  assign a_mag = a_neg ? -src_a : src_a;
  assign b_mag = b_neg ? -src_b : src_b;

  // ---------------------------------------------------------------- datapath steps
  // Multiply: right-shifting accumulator, multiplier bits consumed LSB first.
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (op_b[0] ? {1'b0, op_a} : '0);

  // Divide: acc upper half is the partial remainder, lower half collects quotient bits.
  assign div_shift = {acc[2*WIDTH-1:WIDTH], op_a[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, op_b};
  assign div_qbit  = ~div_diff[WIDTH];
  assign div_rem   = div_qbit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];

  assign prod_res = (neg_a ^ neg_b) ? -acc : acc;
  assign quot_res = (neg_a ^ neg_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_res  = neg_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_mul) begin
          state_nxt = MUL;
        end else if (start_div) begin
          state_nxt = DIV;
        end
      end
      MUL: if (cnt == CNT_LAST) state_nxt = FIX;
      DIV: if (cnt == CNT_LAST) state_nxt = FIX;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      acc      <= '0;
      op_a     <= '0;
      op_b     <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      op_div   <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start_mul || start_div) begin
            op_a   <= a_mag;
            op_b   <= b_mag;
            neg_a  <= a_neg;
            neg_b  <= b_neg;
            op_div <= is_div;
            acc    <= '0;
            cnt    <= '0;
          end else if (div0) begin
            lo       <= '1;
            hi       <= src_a;
            done     <= 1'b1;
            div_zero <= 1'b1;
          end else if (go && is_mthi) begin
            hi <= src_a;
          end else if (go && is_mtlo) begin
            lo <= src_a;
          end
        end
        MUL: begin
          acc  <= {mul_sum, acc[WIDTH-1:1]};
          op_b <= op_b >> 1;
          cnt  <= cnt + CNT_ONE;
        end
        DIV: begin
          acc  <= {div_rem, acc[WIDTH-2:0], div_qbit};
          op_a <= op_a << 1;
          cnt  <= cnt + CNT_ONE;
        end
        default: begin
          if (op_div) begin
            hi <= rem_res;
            lo <= quot_res;
          end else begin
            {hi, lo} <= prod_res;
          end
          done <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_muldiv_ctrl.sv
// ============================================================================
// Module   : tb_alu_muldiv_ctrl
// Purpose  : Directed self-checking bench with expected-result scoreboard
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_muldiv_ctrl;

  localparam int W = 32;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_ADD   = 6'b100000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   AluOp = 2'b00;
  logic [5:0]   FnField = 6'b000000;
  logic         issue = 1'b0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic [3:0]   AluCtrl;
  logic         illegal;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic         stall;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  typedef struct packed {
    logic [1:0] op;
    logic [5:0] fn;
    logic [3:0] ctrl;
    logic       ill;
  } dec_t;

  exp_t scb[$];

  alu_muldiv_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .AluOp    (AluOp),
    .FnField  (FnField),
    .issue    (issue),
    .src_a    (src_a),
    .src_b    (src_b),
    .AluCtrl  (AluCtrl),
    .illegal  (illegal),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .stall    (stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t               e;
    logic signed [63:0] sp;
    logic [63:0]        up;
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sbv;
    e = '0;
    if (fn == F_MULT) begin
      sp = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
      {e.hi, e.lo} = sp;
    end else if (fn == F_MULTU) begin
      up = {32'd0, a} * {32'd0, b};
      {e.hi, e.lo} = up;
    end else if (b == '0) begin
      e.hi = a;
      e.lo = '1;
      e.dz = 1'b1;
    end else if (fn == F_DIV) begin
      sa   = a;
      sbv  = b;
      e.lo = sa / sbv;
      e.hi = sa % sbv;
    end else begin
      e.lo = a / b;
      e.hi = a % b;
    end
    return e;
  endfunction

  // Issue one mul/div, wait for done within a bounded window, then check against the scoreboard.
  task automatic run_md(input string tag, input logic [5:0] fn, input logic [W-1:0] a,
                        input logic [W-1:0] b, input exp_t e);
    exp_t exp_v;
    int   n;
    scb.push_back(e);
    AluOp   = 2'b10;
    FnField = fn;
    src_a   = a;
    src_b   = b;
    issue   = 1'b1;
    #1;
    chk({tag, "_idle_stall"}, stall, 0);
    tick();
    issue   = 1'b0;
    FnField = F_ADD;
    src_a   = 32'h0BAD_F00D;
    src_b   = 32'h0000_0000;
    chk({tag, "_busy_at_accept"}, busy, e.dz ? 0 : 1);
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, e.dz ? 0 : W + 1);
    exp_v = scb.pop_front();
    chk({tag, "_hi"}, hi, exp_v.hi);
    chk({tag, "_lo"}, lo, exp_v.lo);
    chk({tag, "_div_zero"}, div_zero, exp_v.dz);
    chk({tag, "_busy_at_done"}, busy, 0);
    tick();
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_hold"}, {hi, lo}, {exp_v.hi, exp_v.lo});
  endtask

  dec_t dec_tab [22] = '{
    '{2'b00, 6'b100010, 4'b0010, 1'b0},
    '{2'b01, 6'b111111, 4'b0110, 1'b0},
    '{2'b11, 6'b000000, 4'b0001, 1'b0},
    '{2'b10, 6'b100000, 4'b0010, 1'b0},
    '{2'b10, 6'b100010, 4'b0110, 1'b0},
    '{2'b10, 6'b100100, 4'b0000, 1'b0},
    '{2'b10, 6'b100101, 4'b0001, 1'b0},
    '{2'b10, 6'b100110, 4'b0011, 1'b0},
    '{2'b10, 6'b100111, 4'b1100, 1'b0},
    '{2'b10, 6'b101010, 4'b0111, 1'b0},
    '{2'b10, 6'b101011, 4'b1000, 1'b0},
    '{2'b10, 6'b011000, 4'b0010, 1'b0},
    '{2'b10, 6'b011001, 4'b0010, 1'b0},
    '{2'b10, 6'b011010, 4'b0010, 1'b0},
    '{2'b10, 6'b011011, 4'b0010, 1'b0},
    '{2'b10, 6'b010000, 4'b0010, 1'b0},
    '{2'b10, 6'b010001, 4'b0010, 1'b0},
    '{2'b10, 6'b010010, 4'b0010, 1'b0},
    '{2'b10, 6'b010011, 4'b0010, 1'b0},
    '{2'b10, 6'b111111, 4'b1111, 1'b1},
    '{2'b10, 6'b000000, 4'b1111, 1'b1},
    '{2'b10, 6'b011100, 4'b1111, 1'b1}
  };

  initial begin
    exp_t         e;
    exp_t         ev;
    int           n;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    // Reset state
    tick();
    tick();
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_div_zero", div_zero, 0);
    rst_n = 1'b1;
    tick();

    // Decode sweep (issue low: FSM must stay idle while decode tracks inputs)
    foreach (dec_tab[i]) begin
      AluOp   = dec_tab[i].op;
      FnField = dec_tab[i].fn;
      #1;
      chk($sformatf("decode_%b_%b", dec_tab[i].op, dec_tab[i].fn), {AluCtrl, illegal},
          {dec_tab[i].ctrl, dec_tab[i].ill});
    end
    AluOp   = 2'b10;
    FnField = F_MULT;
    src_a   = 32'd3;
    src_b   = 32'd4;
    tick();
    tick();
    chk("no_issue_busy", busy, 0);
    chk("no_issue_done", done, 0);

    // Directed mul/div cases with hand-derived expectations
    run_md("mult", F_MULT, 32'hFFFF_FFFF, 32'h0000_0002, '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0});
    run_md("multu", F_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, '{32'h0000_0001, 32'hFFFF_FFFE, 1'b0});
    run_md("div", F_DIV, 32'hFFFF_FFF9, 32'h0000_0002, '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0});
    run_md("divu", F_DIVU, 32'h0000_0064, 32'h0000_0007, '{32'h0000_0002, 32'h0000_000E, 1'b0});
    run_md("divu_zero", F_DIVU, 32'h1234_5678, 32'h0000_0000, '{32'h1234_5678, 32'hFFFF_FFFF, 1'b1});
    run_md("div_zero", F_DIV, 32'h8765_4321, 32'h0000_0000, '{32'h8765_4321, 32'hFFFF_FFFF, 1'b1});
    run_md("div_pos_neg", F_DIV, 32'd100, 32'hFFFF_FFF9, '{32'd2, 32'hFFFF_FFF2, 1'b0});

    // Pseudo-random operands checked against the behavioural model
    for (int k = 0; k < 3; k++) begin
      ra = $urandom;
      rb = $urandom;
      if (rb == '0) rb = 32'd3;
      if (ra == 32'h8000_0000) ra = 32'h8000_0001;
      run_md($sformatf("rnd_mult%0d", k), F_MULT, ra, rb, model(F_MULT, ra, rb));
      run_md($sformatf("rnd_multu%0d", k), F_MULTU, ra, rb, model(F_MULTU, ra, rb));
      run_md($sformatf("rnd_div%0d", k), F_DIV, ra, rb >> k, model(F_DIV, ra, rb >> k));
      run_md($sformatf("rnd_divu%0d", k), F_DIVU, ra, rb >> (8 * k), model(F_DIVU, ra, rb >> (8 * k)));
    end

    // Stall handshake: mflo held while busy; add never stalls; mthi while busy is ignored
    e = model(F_MULT, 32'h0000_1234, 32'hFFFF_FFFD);
    scb.push_back(e);
    AluOp   = 2'b10;
    FnField = F_MULT;
    src_a   = 32'h0000_1234;
    src_b   = 32'hFFFF_FFFD;
    issue   = 1'b1;
    tick();
    FnField = F_MFLO;
    n = 0;
    while (!done && n < 200) begin
      chk("stall_mflo", stall, 1);
      if (n == 5) begin
        FnField = F_ADD;
        #1;
        chk("stall_add", stall, 0);
        chk("stall_add_ctrl", AluCtrl, 4'b0010);
        FnField = F_MFLO;
      end
      if (n == 8) begin
        FnField = F_MTHI;
        src_a   = 32'hDEAD_BEEF;
        #1;
        chk("stall_mthi", stall, 1);
        FnField = F_MFLO;
      end
      tick();
      n++;
    end
    chk("stall_latency", n, W + 1);
    chk("stall_release", stall, 0);
    ev = scb.pop_front();
    chk("stall_hi", hi, ev.hi);
    chk("stall_lo", lo, ev.lo);
    issue = 1'b0;
    tick();
    chk("stall_idle_busy", busy, 0);

    // Asynchronous reset in the middle of a multiply
    FnField = F_MULT;
    src_a   = 32'hFFFF_FFFF;
    src_b   = 32'h0000_0002;
    issue   = 1'b1;
    tick();
    issue = 1'b0;
    repeat (10) tick();
    chk("midrst_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    #2;
    rst_n = 1'b1;
    tick();
    tick();
    chk("midrst_stays_idle", busy, 0);
    chk("midrst_no_done", done, 0);

    // mtlo / mthi after reset
    AluOp   = 2'b10;
    FnField = F_MTLO;
    src_a   = 32'hA5A5_A5A5;
    issue   = 1'b1;
    tick();
    issue = 1'b0;
    chk("mtlo_lo", lo, 32'hA5A5_A5A5);
    chk("mtlo_hi", hi, 0);
    chk("mtlo_busy", busy, 0);
    chk("mtlo_done", done, 0);
    FnField = F_MTHI;
    src_a   = 32'h5A5A_0001;
    issue   = 1'b1;
    tick();
    issue = 1'b0;
    chk("mthi_hi", hi, 32'h5A5A_0001);
    chk("mthi_lo", lo, 32'hA5A5_A5A5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
